legv8_multicycle_control: RTL

- Main control FSM for the multi-cycle LEGv8 datapath; sits directly upstream of the ALU control decoder.
- Decodes instruction[31:21] and sequences fetch / decode / execute / memory / writeback.
- Drives the 2-bit ALUOp that the ALU control decoder turns into a 4-bit ALU code, plus all datapath enables.
- Handles a memory-ready handshake and keeps a retired-instruction counter.

---
 rtl/legv8_multicycle_control.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/legv8_multicycle_control.sv
// Main control FSM for the multi-cycle LEGv8 datapath.
// Sequences fetch/decode/execute/memory/writeback, drives ALUOp and all
// datapath enables, honours the memory-ready handshake, counts retirements.
module legv8_multicycle_control #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [10:0]      opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic [1:0]       alu_op,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_source,
    output logic             ir_write,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             reg2loc,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXEC    = 4'd6;
    localparam logic [3:0] S_RWB     = 4'd7;
    localparam logic [3:0] S_CBZ     = 4'd8;
    localparam logic [3:0] S_BRANCH  = 4'd9;
    localparam logic [3:0] S_ILLEGAL = 4'd10;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [5:0]  OP_B    = 6'b000101;

    logic [3:0]       state_q;
    logic [3:0]       state_d;
    logic             illegal_q;
    logic [CNT_W-1:0] retired_q;
    logic             is_rtype;
    logic             is_ldur;
    logic             is_stur;
    logic             is_cbz;
    logic             is_b;
    logic             retire;

    // The zero flag only qualifies pc_write_cond inside the datapath.
    logic unused_zero;
    assign unused_zero = zero;

    assign state   = state_q;
    assign illegal = illegal_q;
    assign retired = retired_q;

    // Opcode class decode
    always_comb begin
        is_rtype = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                   (opcode == OP_AND) || (opcode == OP_ORR);
        is_ldur  = (opcode == OP_LDUR);
        is_stur  = (opcode == OP_STUR);
        is_cbz   = (opcode[10:3] == OP_CBZ);
        is_b     = (opcode[10:5] == OP_B);
    end

    // Next-state logic
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (is_rtype)               state_d = S_EXEC;
                else if (is_ldur || is_stur) state_d = S_MEMADR;
                else if (is_cbz)            state_d = S_CBZ;
                else if (is_b)              state_d = S_BRANCH;
                else                        state_d = S_ILLEGAL;
            end
            S_MEMADR: begin
                if (is_ldur)      state_d = S_MEMRD;
                else if (is_stur) state_d = S_MEMWR;
                else              state_d = S_FETCH;
            end
            S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:    state_d = S_RWB;
            S_RWB:     state_d = S_FETCH;
            S_CBZ:     state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            S_ILLEGAL: state_d = S_ILLEGAL;
            default:   state_d = S_FETCH;
        endcase
    end

    // Instruction completes on the edge leaving a final state
    always_comb begin
        retire = (state_q == S_MEMWB) || (state_q == S_RWB) ||
                 (state_q == S_CBZ) || (state_q == S_BRANCH) ||
                 ((state_q == S_MEMWR) && mem_ready);
    end

    // State, sticky illegal flag and retired counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_q | (state_d == S_ILLEGAL);
            if (retire)
                retired_q <= retired_q + 1'b1;
        end
    end

    // Per-state control outputs; forced to zero while reset is asserted so
    // nothing is strobed between reset assertion and the next edge.
    always_comb begin
        alu_op        = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        ir_write      = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg2loc       = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    reg2loc   = is_stur || is_cbz;
                end
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEMRD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEMWR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                    reg2loc   = 1'b1;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                S_RWB: begin
                    reg_write = 1'b1;
                end
                S_CBZ: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    reg2loc       = 1'b1;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                end
                S_BRANCH: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                end
                default: ;
            endcase
        end
    end

endmodule
